uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
// - Byte FIFO + drain sequencer sitting directly upstream of svc_uart_tx.
// - Accepts bytes on a valid/ready stream; issues them one at a time on the
//   utx_en/utx_data/utx_busy interface.
// - Replaces ad-hoc muxing of producers onto the UART transmitter.
// - Absorbs bursts (string iterator, echo path) without dropping bytes.
// PARAMETERS
// - DEPTH  16  FIFO entries; power of 2, >= 2. AW = $clog2(DEPTH).
// PORTS
// - clk          in   1     clock
// - rst_n        in   1     reset; asynchronous assert, active-low
// - s_valid      in   1     upstream byte valid
// - s_data       in   8     upstream byte
// - s_ready      out  1     FIFO can accept; equals !full, combinational from state regs
// - utx_en       out  1     one-cycle send strobe to svc_uart_tx (registered)
// - utx_data     out  8     byte to send; held stable from utx_en until busy drops
// - utx_busy     in   1     transmitter busy; rises cycle after utx_en
// - fifo_count   out  AW+1  entries currently stored (0..DEPTH)
// - idle         out  1     FIFO empty AND FSM in ST_IDLE AND !utx_busy
// BEHAVIOUR
// - Reset (async, rst_n=0): wr/rd ptrs=0, count=0, FSM=ST_IDLE, utx_en=0,
//   utx_data=8'h00. Outputs after reset: s_ready=1, idle=1.
// - Reset mid-transmission: FIFO contents discarded; no further utx_en until refill.
// - Push: s_valid && s_ready writes s_data at wr_ptr; wr_ptr wraps mod DEPTH.
// - Pop: occurs only in ST_IDLE->ST_ISSUE; rd_ptr wraps mod DEPTH.
// - Simultaneous push+pop: count unchanged.
// - Full: s_ready=0, s_data ignored.
// - Empty: no pop, FSM stays in ST_IDLE.
// - Pointers are AW+1 bits:
//   - full  = MSBs differ, rest equal
//   - empty = pointers equal
// - FSM states:
//   - ST_IDLE: if !empty && !utx_busy -> pop head into utx_data, utx_en<=1 -> ST_ISSUE.
//   - ST_ISSUE: utx_en<=0 (pulse is exactly 1 cycle) -> ST_HOLD.
//   - ST_HOLD: wait until utx_busy==0 -> ST_IDLE.
// - Timing:
//   - Byte visible in FIFO the cycle after push.
//   - Earliest utx_en is 2 cycles after push into an empty FIFO with tx idle.
//   - Back-to-back bytes: next utx_en no earlier than 2 cycles after busy falls.
// - utx_busy already high in ST_IDLE (foreign transmitter use): FSM waits, never strobes.
// - s_ready does not depend on s_valid; no combinational path s_valid->s_ready.
// CONFIGURATION
// - Macro UART_TX_FIFO_CRLF_EN.
// - Defined: a popped byte 8'h0A is sent as 8'h0D then 8'h0A.
//   - ST_IDLE on head==8'h0A with cr_done==0: do NOT pop; send 8'h0D; set cr_done.
//   - Next ST_IDLE pass: pop, send 8'h0A, clear cr_done.
//   - cr_done resets to 0.
//   - A literal 8'h0D in the FIFO passes unchanged (no dedup).
// - Undefined: all bytes sent verbatim; cr_done logic absent.
// TESTING
// - Reset, then push 8'h41 with tx model idle:
//   -> utx_en 1 cycle, utx_data=8'h41 2 cycles after push; fifo_count 1->0.
// - Push 20 bytes back-to-back (DEPTH=16), tx model busy 100 cycles/byte:
//   -> s_ready drops at count=16; all accepted bytes emerge in order, none duplicated.
// - Push/pop wrap: send 3*DEPTH bytes 0x00..0x2F in bursts of 5:
//   -> output sequence 0x00..0x2F exact; count never exceeds DEPTH.
// - Push at full while pop occurs same cycle:
//   -> push ignored that cycle (s_ready=0); next cycle s_ready=1, push accepted.
// - Assert rst_n=0 mid-byte with 6 bytes queued:
//   -> utx_en=0, count=0, s_ready=1 immediately; no stale byte sent after release.
// - With UART_TX_FIFO_CRLF_EN, push "A\n":
//   -> utx_data sequence 8'h41, 8'h0D, 8'h0A; without macro: 8'h41, 8'h0A.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte stream in, UART strobe out: groups the producer handshake and the svc_uart_tx signals.
// The slave modport is the FIFO; the master modport is the producer plus transmitter side.
interface uart_tx_fifo_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       utx_en;
    logic [7:0] utx_data;
    logic       utx_busy;

    modport slave (
        input  s_valid,
        input  s_data,
        input  utx_busy,
        output s_ready,
        output utx_en,
        output utx_data
    );

    modport master (
        output s_valid,
        output s_data,
        output utx_busy,
        input  s_ready,
        input  utx_en,
        input  utx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-byte FIFO feeding svc_uart_tx one byte per 1-cycle utx_en; UART_TX_FIFO_CRLF_EN expands LF to CR,LF.
// Latency: utx_en 2 cycles after a push into an empty FIFO; backpressure: s_ready = !full, never depends on s_valid.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_fifo_if.slave        bus,
    output logic [AW:0]          fifo_count_o,
    output logic                 idle_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        utx_en_q, utx_en_d;
    logic [7:0]  utx_data_q, utx_data_d;
    logic [7:0]  mem_q [DEPTH];

    logic        full;
    logic        empty;
    logic        push;
    logic [7:0]  head;

    // Extra pointer MSB tells a full FIFO apart from an empty one.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = bus.s_valid && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef UART_TX_FIFO_CRLF_EN
    logic cr_done_q, cr_done_d;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        utx_en_d   = 1'b0;
        utx_data_d = utx_data_q;
`ifdef UART_TX_FIFO_CRLF_EN
        cr_done_d  = cr_done_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (!empty && !bus.utx_busy) begin
`ifdef UART_TX_FIFO_CRLF_EN
                    // LF stays at the head until its CR has gone out.
                    if (head == 8'h0A && !cr_done_q) begin
                        utx_data_d = 8'h0D;
                        cr_done_d  = 1'b1;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + PTR_ONE;
                        utx_data_d = head;
                        cr_done_d  = 1'b0;
                    end
`else
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    utx_data_d = head;
`endif
                    utx_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus.utx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            utx_en_q   <= 1'b0;
            utx_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            utx_en_q   <= utx_en_d;
            utx_data_q <= utx_data_d;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_done_q <= 1'b0;
        end else begin
            cr_done_q <= cr_done_d;
        end
    end
`endif

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.s_data;
        end
    end

    assign bus.s_ready   = !full;
    assign bus.utx_en    = utx_en_q;
    assign bus.utx_data  = utx_data_q;
    assign fifo_count_o  = wr_ptr_q - rd_ptr_q;
    assign idle_o        = empty && (state_q == ST_IDLE) && !bus.utx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vector table for single-byte latency plus hand sequences for
// burst/full, wrap, push-at-full-with-pop, foreign busy, mid-transfer reset and LF handling.
module tb_uart_tx_fifo;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if bus();
    logic [4:0] cnt;
    logic       idle;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .fifo_count_o (cnt),
        .idle_o       (idle)
    );

    int checks   = 0;
    int failures = 0;

    // Transmitter model: busy rises the cycle after utx_en and stays high busy_len cycles.
    int   busy_len   = 3;
    bit   force_busy = 1'b0;
    int   busy_cnt   = 0;
    bit   pend       = 1'b0;
    assign bus.utx_busy = force_busy || (busy_cnt != 0);

    logic [7:0] rx_q[$];
    int         en_total    = 0;
    int         max_cnt     = 0;
    bit         full_rdy_bad = 1'b0;

    always @(negedge clk) begin
        if (bus.utx_en === 1'b1) begin
            rx_q.push_back(bus.utx_data);
            en_total++;
            pend = 1'b1;
        end
        if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        if (cnt == 5'd16 && bus.s_ready !== 1'b0) full_rdy_bad = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (pend) begin
            busy_cnt = busy_len;
            pend     = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (idle !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {31'd0, idle}, 32'd1);
    endtask

    // Offers bytes base, base+1, ... in bursts; a byte advances only when s_ready was high.
    task automatic push_seq(input int n, input int base, input int burst, input int gap);
        int sent  = 0;
        int inb   = 0;
        int gapc  = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (gapc > 0) begin
                bus.s_valid = 1'b0;
                gapc--;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'(base + sent);
                if (bus.s_ready) begin
                    sent++;
                    inb++;
                    if (inb == burst) begin
                        inb  = 0;
                        gapc = gap;
                    end
                end
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        if (sent != n) chk("push_timeout", sent, n);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_dat;
        logic [4:0] exp_cnt_c1;
        logic [4:0] exp_cnt_c2;
    } vec_t;

    vec_t vt[5];
    logic [7:0] crlf_exp[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        vt[0] = '{8'h41, 8'h41, 5'd1, 5'd0};
        vt[1] = '{8'h00, 8'h00, 5'd1, 5'd0};
        vt[2] = '{8'hFF, 8'hFF, 5'd1, 5'd0};
        vt[3] = '{8'h5A, 8'h5A, 5'd1, 5'd0};
        vt[4] = '{8'h0D, 8'h0D, 5'd1, 5'd0};

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_utx_en", {31'd0, bus.utx_en}, 32'd0);
        chk("rst_utx_data", {24'd0, bus.utx_data}, 32'h00);
        chk("rst_count", {27'd0, cnt}, 32'd0);
        rst_n = 1'b1;

        // Single byte into an empty FIFO: strobe appears 2 cycles after the push cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = vt[i].din;
            @(negedge clk);
            bus.s_valid = 1'b0;
            chk("vec_cnt_c1", {27'd0, cnt}, {27'd0, vt[i].exp_cnt_c1});
            chk("vec_en_c1", {31'd0, bus.utx_en}, 32'd0);
            @(negedge clk);
            chk("vec_en_c2", {31'd0, bus.utx_en}, 32'd1);
            chk("vec_dat_c2", {24'd0, bus.utx_data}, {24'd0, vt[i].exp_dat});
            chk("vec_cnt_c2", {27'd0, cnt}, {27'd0, vt[i].exp_cnt_c2});
            @(negedge clk);
            chk("vec_en_c3", {31'd0, bus.utx_en}, 32'd0);
            chk("vec_dat_hold", {24'd0, bus.utx_data}, {24'd0, vt[i].exp_dat});
            wait_idle(50);
        end

        // 20-byte burst against a slow transmitter.
        busy_len = 100;
        rx_q.delete();
        max_cnt = 0;
        full_rdy_bad = 1'b0;
        push_seq(20, 8'h60, 20, 0);
        wait_idle(5000);
        chk("burst_max_cnt", max_cnt, 32'd16);
        chk("burst_rdy_at_full", {31'd0, full_rdy_bad}, 32'd0);
        chk("burst_rx_size", rx_q.size(), 32'd20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++)
            chk("burst_rx_byte", {24'd0, rx_q[i]}, 32'(8'h60 + i));

        // Pointer wrap: 48 bytes in bursts of 5.
        busy_len = 2;
        rx_q.delete();
        max_cnt = 0;
        push_seq(48, 0, 5, 3);
        wait_idle(2000);
        chk("wrap_cnt_bound", {31'd0, max_cnt <= 16}, 32'd1);
        chk("wrap_rx_size", rx_q.size(), 32'd48);
        for (int i = 0; i < 48 && i < rx_q.size(); i++)
            chk("wrap_rx_byte", {24'd0, rx_q[i]}, i);

        // Foreign busy holds the FSM off; then push at full coincides with the first pop.
        rx_q.delete();
        n0 = en_total;
        force_busy = 1'b1;
        push_seq(16, 8'h80, 16, 0);
        repeat (5) @(negedge clk);
        chk("full_cnt", {27'd0, cnt}, 32'd16);
        chk("full_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("foreign_busy_no_en", en_total - n0, 32'd0);
        chk("foreign_busy_idle", {31'd0, idle}, 32'd0);
        force_busy  = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        @(negedge clk);
        chk("fullpop_cnt", {27'd0, cnt}, 32'd15);
        chk("fullpop_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("fullpop_en", {31'd0, bus.utx_en}, 32'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("fullpop_accept_cnt", {27'd0, cnt}, 32'd16);
        wait_idle(500);
        chk("fullpop_rx_size", rx_q.size(), 32'd17);
        if (rx_q.size() == 17) begin
            chk("fullpop_first", {24'd0, rx_q[0]}, 32'h80);
            chk("fullpop_last", {24'd0, rx_q[16]}, 32'hAA);
        end

        // Reset while a byte is in flight and 6 more are queued.
        busy_len = 50;
        rx_q.delete();
        push_seq(7, 8'hC0, 7, 0);
        repeat (5) @(negedge clk);
        chk("midrst_queued", {27'd0, cnt}, 32'd6);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", {31'd0, bus.utx_en}, 32'd0);
        chk("midrst_cnt", {27'd0, cnt}, 32'd0);
        chk("midrst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = rx_q.size();
        repeat (150) @(negedge clk);
        chk("midrst_no_stale", rx_q.size(), n0);
        chk("midrst_idle", {31'd0, idle}, 32'd1);
        busy_len = 3;
        push_seq(1, 8'h3C, 1, 0);
        wait_idle(200);
        chk("midrst_refill_size", rx_q.size(), n0 + 1);
        if (rx_q.size() == n0 + 1)
            chk("midrst_refill_byte", {24'd0, rx_q[n0]}, 32'h3C);

        // "A\n"
        rx_q.delete();
`ifdef UART_TX_FIFO_CRLF_EN
        crlf_exp = '{8'h41, 8'h0D, 8'h0A};
`else
        crlf_exp = '{8'h41, 8'h0A};
`endif
        push_seq(1, 8'h41, 1, 0);
        push_seq(1, 8'h0A, 1, 0);
        wait_idle(200);
        chk("lf_rx_size", rx_q.size(), crlf_exp.size());
        for (int i = 0; i < crlf_exp.size() && i < rx_q.size(); i++)
            chk("lf_rx_byte", {24'd0, rx_q[i]}, {24'd0, crlf_exp[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
